// File: rtl/saper_pkg.sv
// Shared definitions for the Saper board sequencer: tile word layout,
// sequencer states, board geometry and the neighbour walk order.
package saper_pkg;

   localparam int MAX_DIM = 16;
   localparam int AW      = $clog2(MAX_DIM * MAX_DIM);
   localparam int XW      = $clog2(MAX_DIM);

   // Tile word bit positions; bits 3:0 hold the neighbour mine count
   localparam int TILE_BOMB = 7;
   localparam int TILE_REV  = 6;
   localparam int TILE_FLAG = 5;

   typedef enum logic [3:0] {
      IDLE, PLAY, RD, CHK, POP, NRD, NCHK, WIN, LOSE
   } state_t;

   // Neighbour offsets as 2-bit two's complement, entry 0 = (dy,dx)=(-1,-1)
   // through entry 7 = (+1,+1), centre excluded
   localparam logic [7:0][1:0] NBR_DY = {2'b01, 2'b01, 2'b01, 2'b00,
                                         2'b00, 2'b11, 2'b11, 2'b11};
   localparam logic [7:0][1:0] NBR_DX = {2'b01, 2'b00, 2'b11, 2'b01,
                                         2'b11, 2'b01, 2'b00, 2'b11};

   // Neighbour coordinate in 6-bit signed form: bit5 set means off the low edge
   function automatic logic [5:0] nbr_coord(input logic [XW-1:0] c, input logic [1:0] d);
      return 6'(c) + {{4{d[1]}}, d};
   endfunction

endpackage

// File: rtl/tile_fifo.sv
// Flood-fill work queue: synchronous FIFO of tile addresses with flush.
// Read data is registered and held until the next pop.
module tile_fifo import saper_pkg::*; #(
   parameter int DEPTH = MAX_DIM * MAX_DIM,
   parameter int DW    = AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [DW-1:0] mem_arr [DEPTH];
   logic [DW-1:0] pop_data_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          do_push, do_pop;

   assign empty    = (count_reg == '0);
   assign do_pop   = pop && !empty && !flush;
   assign do_push  = push && !flush && ((count_reg != FULL_CNT) || do_pop);
   assign pop_data = pop_data_reg;

   // Storage array and registered read port
   always_ff @(posedge clk) begin
      if (do_push) mem_arr[wr_ptr_reg] <= push_data;
      if (do_pop)  pop_data_reg <= mem_arr[rd_ptr_reg];
   end

   // Pointer and occupancy bookkeeping; flush empties the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (do_push && !do_pop)      count_reg <= count_reg + (PW+1)'(1);
         else if (!do_push && do_pop) count_reg <= count_reg - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/tile_ctl.sv
// Saper game sequencer: click handling, flag/reveal, queue-driven flood fill,
// win/lose detection, and renderer-priority sharing of the tile RAM port.
module tile_ctl import saper_pkg::*; (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [4:0]    board_size,
   input  logic [7:0]    bomb_total,
   input  logic          click_valid,
   output logic          click_ready,
   input  logic [4:0]    click_x,
   input  logic [4:0]    click_y,
   input  logic          click_left,
   input  logic          click_right,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   input  logic          draw_req,
   input  logic [AW-1:0] draw_addr,
   output logic          draw_rvalid,
   output logic          busy,
   output logic          win,
   output logic          lose,
   output logic [7:0]    flag_cnt,
   output logic [8:0]    revealed_cnt
);

   state_t        state_reg;
   logic [4:0]    size_reg;
   logic [7:0]    bombs_reg;
   logic [XW-1:0] cx_reg, cy_reg;
   logic          right_reg;
   logic [2:0]    nbr_reg;
   logic          nbr_ok_reg, rd_issued_reg, draw_rvalid_reg, win_reg, lose_reg;
   logic [7:0]    hold_reg, flag_cnt_reg;
   logic [8:0]    rev_cnt_reg;

   logic          q_push, q_pop, q_empty;
   logic [AW-1:0] q_push_data, q_head;
   logic [AW-1:0] ctl_addr, click_addr, nbr_addr;
   logic          ctl_we, click_ok, nbr_in, go;
   logic [7:0]    ctl_wdata, word;
   logic [5:0]    nx, ny;
   logic [9:0]    board_sq, win_target;
   logic [8:0]    rev_inc;

   tile_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .flush     (start),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .pop_data  (q_head),
      .empty     (q_empty)
   );

   // A stalled read leaves its data in hold_reg, so CHK/NCHK use that on retry
   assign word       = rd_issued_reg ? mem_rdata : hold_reg;
   assign click_addr = {cy_reg, cx_reg};
   assign click_ok   = (click_x < size_reg) && (click_y < size_reg) && (click_left ^ click_right);
   assign nx         = nbr_coord(q_head[XW-1:0], NBR_DX[nbr_reg]);
   assign ny         = nbr_coord(q_head[AW-1:XW], NBR_DY[nbr_reg]);
   assign nbr_in     = !nx[5] && !ny[5] && (nx[4:0] < size_reg) && (ny[4:0] < size_reg);
   assign nbr_addr   = {ny[XW-1:0], nx[XW-1:0]};
   assign board_sq   = {5'd0, size_reg} * {5'd0, size_reg};
   assign win_target = board_sq - {2'd0, bombs_reg};
   assign rev_inc    = (rev_cnt_reg == 9'h1FF) ? rev_cnt_reg : rev_cnt_reg + 9'd1;
   assign go         = !draw_req && !start;

   // Renderer always wins the port; controller writes are suppressed meanwhile
   assign mem_addr     = draw_req ? draw_addr : ctl_addr;
   assign mem_we       = ctl_we;
   assign mem_wdata    = ctl_wdata;
   assign draw_rvalid  = draw_rvalid_reg;
   assign click_ready  = (state_reg == PLAY);
   assign busy         = (state_reg inside {RD, CHK, POP, NRD, NCHK});
   assign win          = win_reg;
   assign lose         = lose_reg;
   assign flag_cnt     = flag_cnt_reg;
   assign revealed_cnt = rev_cnt_reg;

   // Controller RAM access, tile update word and queue push/pop per state
   always_comb begin
      ctl_addr    = '0;
      ctl_we      = 1'b0;
      ctl_wdata   = '0;
      q_push      = 1'b0;
      q_push_data = nbr_addr;
      q_pop       = 1'b0;
      unique case (state_reg)
         RD:  ctl_addr = click_addr;
         CHK: begin
            ctl_addr    = click_addr;
            q_push_data = click_addr;
            if (go) begin
               if (right_reg) begin
                  if (!word[TILE_REV]) begin
                     ctl_we    = 1'b1;
                     ctl_wdata = word ^ (8'd1 << TILE_FLAG);
                  end
               end else if (!word[TILE_FLAG] && !word[TILE_REV]) begin
                  ctl_we    = 1'b1;
                  ctl_wdata = word | (8'd1 << TILE_REV);
                  q_push    = !word[TILE_BOMB] && (word[3:0] == 4'd0);
               end
            end
         end
         POP:  q_pop = !start && !q_empty;
         NRD:  ctl_addr = nbr_addr;
         NCHK: begin
            ctl_addr = nbr_addr;
            if (go && nbr_ok_reg && (word[7:5] == 3'b000)) begin
               ctl_we    = 1'b1;
               ctl_wdata = word | (8'd1 << TILE_REV);
               q_push    = (word[3:0] == 4'd0);
            end
         end
         default: ;
      endcase
   end

   // Sequencer state, counters and terminal flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         size_reg        <= '0;
         bombs_reg       <= '0;
         cx_reg          <= '0;
         cy_reg          <= '0;
         right_reg       <= 1'b0;
         nbr_reg         <= '0;
         nbr_ok_reg      <= 1'b0;
         rd_issued_reg   <= 1'b0;
         hold_reg        <= '0;
         draw_rvalid_reg <= 1'b0;
         win_reg         <= 1'b0;
         lose_reg        <= 1'b0;
         flag_cnt_reg    <= '0;
         rev_cnt_reg     <= '0;
      end else begin
         draw_rvalid_reg <= draw_req;
         rd_issued_reg   <= 1'b0;
         if (rd_issued_reg) hold_reg <= mem_rdata;
         if (start) begin
            state_reg    <= PLAY;
            size_reg     <= (board_size > 5'(MAX_DIM)) ? 5'(MAX_DIM) : board_size;
            bombs_reg    <= bomb_total;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
            flag_cnt_reg <= '0;
            rev_cnt_reg  <= '0;
         end else begin
            unique case (state_reg)
               PLAY: if (click_valid && click_ok) begin
                  cx_reg    <= click_x[XW-1:0];
                  cy_reg    <= click_y[XW-1:0];
                  right_reg <= click_right;
                  state_reg <= RD;
               end
               RD: if (!draw_req) begin
                  rd_issued_reg <= 1'b1;
                  state_reg     <= CHK;
               end
               CHK: if (!draw_req) begin
                  if (right_reg) begin
                     if (!word[TILE_REV]) begin
                        if (word[TILE_FLAG])
                           flag_cnt_reg <= (flag_cnt_reg == 8'd0) ? 8'd0 : flag_cnt_reg - 8'd1;
                        else
                           flag_cnt_reg <= (flag_cnt_reg == 8'hFF) ? 8'hFF : flag_cnt_reg + 8'd1;
                     end
                     state_reg <= PLAY;
                  end else if (word[TILE_FLAG] || word[TILE_REV]) begin
                     state_reg <= PLAY;
                  end else if (word[TILE_BOMB]) begin
                     lose_reg  <= 1'b1;
                     state_reg <= LOSE;
                  end else begin
                     rev_cnt_reg <= rev_inc;
                     if (word[3:0] == 4'd0) begin
                        state_reg <= POP;
                     end else if ({1'b0, rev_inc} == win_target) begin
                        win_reg   <= 1'b1;
                        state_reg <= WIN;
                     end else begin
                        state_reg <= PLAY;
                     end
                  end
               end
               POP: if (q_empty) begin
                  if ({1'b0, rev_cnt_reg} == win_target) begin
                     win_reg   <= 1'b1;
                     state_reg <= WIN;
                  end else begin
                     state_reg <= PLAY;
                  end
               end else begin
                  nbr_reg   <= '0;
                  state_reg <= NRD;
               end
               NRD: if (!draw_req) begin
                  rd_issued_reg <= nbr_in;
                  nbr_ok_reg    <= nbr_in;
                  state_reg     <= NCHK;
               end
               NCHK: if (!draw_req) begin
                  if (nbr_ok_reg && (word[7:5] == 3'b000)) rev_cnt_reg <= rev_inc;
                  if (nbr_reg == 3'd7) begin
                     state_reg <= POP;
                  end else begin
                     nbr_reg   <= nbr_reg + 3'd1;
                     state_reg <= NRD;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/tile_ctl.md
# tile_ctl

Game sequencer for the Saper board. It accepts decoded mouse clicks (tile index plus left/right), performs reveal, flag and flood-fill operations on the external board tile RAM, and detects win/lose. It also arbitrates the single RAM port between itself and the board renderer. It sits between detect_index and the board memory; the renderer reads tile state through this block's draw port.

## Interface
- MAX_DIM, 16: maximum board edge in tiles; RAM depth is MAX_DIM².
- AW, $clog2(MAX_DIM*MAX_DIM): RAM address width; address = y*MAX_DIM + x.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse: latch board_size/bomb_total and enter PLAY.
- board_size  input  5  active edge length, 2..MAX_DIM.
- bomb_total  input  8  number of mines on the board.
- click_valid  input  1  click strobe, accepted only when click_ready=1.
- click_ready  output  1  high only in PLAY.
- click_x, click_y  input  5  tile index.
- click_left, click_right  input  1  button qualifiers.
- mem_addr  output  AW  RAM address (shared).
- mem_we  output  1  RAM write enable.
- mem_wdata  output  8  tile write data.
- mem_rdata  input  8  tile read data, 1-cycle latency.
- draw_req  input  1  renderer read request.
- draw_addr  input  AW  renderer address.
- draw_rvalid  output  1  draw data valid on mem_rdata.
- busy  output  1  high in every state except IDLE, PLAY, WIN, LOSE.
- win, lose  output  1  terminal status, held until start or reset.
- flag_cnt  output  8  flags currently placed.
- revealed_cnt  output  9  tiles revealed.

## Operation
- Tile word: bit7 bomb, bit6 revealed, bit5 flagged, bits3:0 neighbour count 0..8. Bomb and count bits are pre-loaded by the layout generator before start. The controller writes only bits 6/5 and always rewrites the word it read.
- States: IDLE, PLAY, RD, CHK, POP, NRD, NCHK, WIN, LOSE.
- IDLE: wait for start. start clears win, lose, flag_cnt and revealed_cnt and goes to PLAY. start is honoured in every state and aborts any operation in progress, with the queue flushed.
- PLAY: click_ready=1. Click handling:
  - Click with x or y ≥ board_size, or with both buttons (or neither) set: dropped.
  - Otherwise go to RD and read the tile.
- CHK, right click:
  - Hidden tile: toggle flag and adjust flag_cnt.
  - Revealed tile: no-op.
  - Return to PLAY.
- CHK, left click:
  - Flagged or revealed tile: no-op, return to PLAY.
  - Bomb: set revealed, go to LOSE.
  - Otherwise: set revealed, revealed_cnt++. If count==0, push the index onto the queue and go to POP; else go to PLAY.
- POP: queue empty → PLAY, or WIN when revealed_cnt == board_size² − bomb_total. Otherwise pop an index and iterate its 8 neighbours in fixed order (dy,dx) = (−1,−1)…(+1,+1), skipping the centre and any out-of-bounds neighbour.
- NRD/NCHK: read the neighbour.
  - If it is hidden, not flagged and not a bomb: write revealed, revealed_cnt++, and push it if its count==0.
  - After the 8th neighbour, go back to POP.
  - A tile is marked revealed at push time, so each tile is queued at most once and a queue of MAX_DIM² entries never overflows.
- The win check also runs after every single-tile reveal in CHK.
- WIN/LOSE: clicks ignored; exit only via start or reset.
- Arithmetic: neighbour coordinates are computed in 6-bit signed form; bounds are 0 ≤ c < board_size. Counters saturate at their maximum.

## Timing
- Reset values:
  - State IDLE.
  - click_ready, busy, win, lose, mem_we, draw_rvalid = 0.
  - mem_addr, mem_wdata, flag_cnt, revealed_cnt = 0.
  - Queue empty.
- RAM contents are not touched by reset.
- Arbitration: draw_req has absolute priority. In a cycle with draw_req=1, mem_addr=draw_addr and mem_we=0. draw_rvalid=1 exactly one cycle later.
- Controller accesses are stalled while draw_req=1. The controller holds its state and retries next cycle. A stalled read does not consume the following cycle's rdata.
- Uncontended costs:
  - Click to result: 3 cycles (accept→RD, rdata→CHK/write, →PLAY).
  - Each neighbour: 2 cycles (read, check/write).
  - Each pop: 1 cycle plus 16 cycles of neighbour work.
- win/lose assert the cycle the state enters WIN/LOSE.
- Reset mid flood-fill: immediate return to IDLE. Tiles already marked revealed stay revealed in RAM; re-running the layout generator is required.

## Structure
- saper_pkg holds: tile bit positions (TILE_BOMB=7, TILE_REV=6, TILE_FLAG=5), the state enum, MAX_DIM, and the neighbour offset table.
- Sub-module tile_fifo: synchronous FIFO, MAX_DIM² × AW, with push/pop/empty/flush. Push and pop may occur in the same cycle.

## Test plan
- 4×4 board, bomb at (0,0) count 0 else, left click (3,3) → flood reveals 15 tiles, revealed_cnt=15, win=1, bomb tile revealed bit stays 0.
- Left click on bomb (2,1) → lose=1 within 3 cycles, word at addr 2*16+1 has bit6 set, further clicks ignored (click_ready=0).
- Right click (1,1) twice → flag_cnt 1 then 0, bit5 toggles. Left click on a flagged tile → RAM unchanged.
- draw_req held high for 10 cycles during a flood fill → draw_rvalid follows each request by 1 cycle. Final RAM and revealed_cnt are identical to the uncontended run.
- Click (5,0) on a 4×4 board, and a click with both buttons set → dropped, state stays PLAY, no RAM write.
- rst low mid flood fill → all outputs return to reset values asynchronously. start after the board reload → fresh PLAY with counters at 0.
